// File: rtl/accumulator_drain_unit.sv
// Drains a finished accumulator tile row by row through ReLU, rounding shift and int8 saturation,
// then writes the packed rows into the unified buffer behind a small credit-limited output FIFO.
module accumulator_drain_unit #(
  parameter int unsigned MUL_SIZE   = 32,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [9:0]                  num_rows_i,
  input  logic [11:0]                 ub_base_addr_i,
  input  logic [4:0]                  shift_i,
  input  logic                        relu_en_i,
  output logic                        acc_rd_en_o,
  output logic [9:0]                  acc_rd_addr_o,
  input  logic [MUL_SIZE*ACC_W-1:0]   acc_rd_data_i,
  output logic                        ub_wr_en_o,
  output logic [11:0]                 ub_wr_addr_o,
  output logic [MUL_SIZE*OUT_W-1:0]   ub_wr_data_o,
  input  logic                        ub_wr_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [ACC_W:0] SatMax = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] SatMin = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {StIdle, StDrain, StFinish} state_e;

  state_e                    r_state;
  logic [9:0]                r_num_rows;
  logic [11:0]               r_base;
  logic [4:0]                r_shift;
  logic                      r_relu;
  logic                      r_busy;
  logic                      r_done;
  logic [9:0]                r_rd_cnt;
  logic [9:0]                r_wr_cnt;
  logic                      r_inflight;
  logic [MUL_SIZE*OUT_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]           r_wr_ptr;
  logic [PtrW-1:0]           r_rd_ptr;
  logic [CntW-1:0]           r_fifo_cnt;

  logic                      w_rd_en;
  logic                      w_wr_en;
  logic                      w_push;
  logic                      w_pop;
  logic [MUL_SIZE*OUT_W-1:0] w_proc;

  // One extra bit keeps the rounding add from overflowing.
  function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] a, input logic [4:0] sh,
                                               input logic relu);
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;
    x = $signed({a[ACC_W-1], a});
    if (relu && x[ACC_W]) x = '0;
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    y = (x + rnd) >>> sh;
    if (y > SatMax)      requant = SatMax[OUT_W-1:0];
    else if (y < SatMin) requant = SatMin[OUT_W-1:0];
    else                 requant = y[OUT_W-1:0];
  endfunction

  always_comb begin
    w_proc = '0;
    for (int unsigned l = 0; l < MUL_SIZE; l++) begin
      w_proc[l*OUT_W +: OUT_W] = requant(acc_rd_data_i[l*ACC_W +: ACC_W], r_shift, r_relu);
    end
  end

  // Credit check counts the in-flight read so the FIFO can never overflow.
  assign w_rd_en = (r_state == StDrain) && (r_rd_cnt < r_num_rows) &&
                   (({1'b0, r_fifo_cnt} + {{CntW{1'b0}}, r_inflight}) < (CntW+1)'(FIFO_DEPTH));
  assign w_wr_en = (r_fifo_cnt != '0);
  assign w_push  = r_inflight;
  assign w_pop   = w_wr_en && ub_wr_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_proc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CntW'(1);
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_num_rows <= '0;
      r_base     <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + 10'd1;
      if (w_pop)   r_wr_cnt <= r_wr_cnt + 10'd1;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_num_rows <= num_rows_i;
            r_base     <= ub_base_addr_i;
            r_shift    <= shift_i;
            r_relu     <= relu_en_i;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_busy     <= 1'b1;
            r_state    <= (num_rows_i == 10'd0) ? StFinish : StDrain;
          end
        end
        StDrain: begin
          if (w_pop && (r_wr_cnt == r_num_rows - 10'd1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StFinish;
          end
        end
        StFinish: begin
          // An empty drain arrives here with done still low and raises it one cycle later.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign acc_rd_en_o   = w_rd_en;
  assign acc_rd_addr_o = r_rd_cnt;
  assign ub_wr_en_o    = w_wr_en;
  assign ub_wr_addr_o  = r_base + {2'b00, r_wr_cnt};
  assign ub_wr_data_o  = w_wr_en ? r_fifo_mem[r_rd_ptr] : '0;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule
